// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared types and helpers for the AXI4 RAM slave.
//   - burst type encodings (FIXED/INCR/WRAP), response codes
//   - write and read FSM state enums
//   - next_addr(): address of the following beat of a burst
// Optional feature macro: AXI_RAM_WRAP_BURST_EN (WRAP bursts supported when
// defined; otherwise WRAP is handled exactly like INCR).
package axi_ram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef AXI_RAM_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  // Address of the next beat. Works on a 32-bit container; the caller
  // truncates to its address width, which gives the modulo-2^N wrap.
  // max_size is log2 of the bus width in bytes; larger SIZE values clamp.
  // Reserved burst 2'b11 falls into the INCR default.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst,
                                            input logic [2:0]  max_size);
    logic [2:0]  eff_size;
    logic [31:0] bytes;
    logic [31:0] incr;
    logic [31:0] win;
    logic [31:0] wrapped;
    logic [31:0] result;
    eff_size = (size > max_size) ? max_size : size;
    bytes    = 32'd1 << eff_size;
    incr     = (addr & ~(bytes - 32'd1)) + bytes;
    // WRAP window is (LEN+1) beats, aligned to its own size.
    win      = bytes * ({24'd0, len} + 32'd1);
    wrapped  = (addr & ~(win - 32'd1)) | (incr & (win - 32'd1));
    case (burst)
      BURST_FIXED: result = addr;
      BURST_WRAP:  result = WRAP_EN ? wrapped : incr;
      default:     result = incr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi_if.sv
// axi_if: AXI4 signal bundle with master and slave modports.
// Parameters: ID_W_WIDTH (AWID/BID), ID_R_WIDTH (ARID/RID), ADDR_WIDTH,
// DATA_WIDTH, BYTE_WIDTH (one WSTRB bit per BYTE_WIDTH data bits).
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where VALID and READY are both 1; VALID, once raised, holds its payload
// stable until that edge.
interface axi_if #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  logic [ID_W_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_W_WIDTH-1:0] bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_R_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_R_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_ram_mem.sv
// axi_ram_mem: word-organised RAM with per-lane write enables.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we/waddr/wdata/wstrb  write port; lanes with wstrb=1 are written
//   re/raddr/rdata    registered read port; rdata holds when re=0
// Same-cycle write and read of one word returns the old contents.
// The array itself has no reset.
module axi_ram_mem #(
  parameter int WORD_AW    = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [WORD_AW-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wstrb,
  input  logic                             re,
  input  logic [WORD_AW-1:0]               raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** WORD_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave on-chip RAM, one write and one read burst in
// flight at a time on independent channels.
// Ports:
//   clk, rst_n     single clock, asynchronous active-low reset
//   axi_s          axi_if slave modport (AW/W/B/AR/R channels)
//   w_state_dbg    current write FSM state
//   r_state_dbg    current read FSM state
// Optional feature macro: AXI_RAM_WRAP_BURST_EN enables WRAP bursts
// (handled inside axi_ram_pkg::next_addr).
// Write: W_IDLE -> W_DATA (LEN+1 beats, WLAST ignored) -> W_RESP (until BREADY).
// Read:  R_IDLE -> R_FETCH (memory word into RDATA) -> R_DATA (until RREADY),
//        looping through R_FETCH per beat, so RVALID drops between beats.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  axi_if.slave     axi_s,
  output w_state_t w_state_dbg,
  output r_state_t r_state_dbg
);
  localparam int LANES     = DATA_WIDTH / BYTE_WIDTH;
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int WORD_AW   = ADDR_WIDTH - LANE_BITS;
  localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);

  // ---------------- write channel state ----------------
  w_state_t              w_state;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_W_WIDTH-1:0] wid_q, bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;

  // ---------------- read channel state ----------------
  r_state_t              r_state;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_R_WIDTH-1:0] rid_lat_q, rid_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;

  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign mem_we = (w_state == W_DATA) && axi_s.wvalid;
  assign mem_re = (r_state == R_FETCH);

  axi_ram_mem #(
    .WORD_AW   (WORD_AW),
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .waddr(waddr_q[ADDR_WIDTH-1:LANE_BITS]),
    .wdata(axi_s.wdata),
    .wstrb(axi_s.wstrb),
    .re   (mem_re),
    .raddr(raddr_q[ADDR_WIDTH-1:LANE_BITS]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi_s.awvalid) begin
            wid_q     <= axi_s.awid;
            waddr_q   <= axi_s.awaddr;
            wlen_q    <= axi_s.awlen;
            wsize_q   <= axi_s.awsize;
            wburst_q  <= axi_s.awburst;
            wcnt_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi_s.wvalid) begin
            waddr_q <= ADDR_WIDTH'(next_addr(32'(waddr_q), wsize_q, wlen_q, wburst_q, MAX_SIZE));
            // Beat count, not WLAST, ends the burst.
            if (wcnt_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
              bresp_q  <= RESP_OKAY;
              w_state  <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi_s.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: begin
          w_state   <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rid_lat_q <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_s.arvalid) begin
            rid_lat_q <= axi_s.arid;
            raddr_q   <= axi_s.araddr;
            rlen_q    <= axi_s.arlen;
            rsize_q   <= axi_s.arsize;
            rburst_q  <= axi_s.arburst;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            r_state   <= R_FETCH;
          end
        end
        R_FETCH: begin
          // The memory read register loads RDATA on this same edge.
          rvalid_q <= 1'b1;
          rid_q    <= rid_lat_q;
          rresp_q  <= RESP_OKAY;
          rlast_q  <= (rcnt_q == rlen_q);
          r_state  <= R_DATA;
        end
        R_DATA: begin
          if (axi_s.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              raddr_q <= ADDR_WIDTH'(next_addr(32'(raddr_q), rsize_q, rlen_q, rburst_q, MAX_SIZE));
              rcnt_q  <= rcnt_q + 8'd1;
              r_state <= R_FETCH;
            end
          end
        end
        default: begin
          r_state   <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign axi_s.awready = awready_q;
  assign axi_s.wready  = wready_q;
  assign axi_s.bvalid  = bvalid_q;
  assign axi_s.bid     = bid_q;
  assign axi_s.bresp   = bresp_q;
  assign axi_s.arready = arready_q;
  assign axi_s.rvalid  = rvalid_q;
  assign axi_s.rlast   = rlast_q;
  assign axi_s.rid     = rid_q;
  assign axi_s.rresp   = rresp_q;
  assign axi_s.rdata   = mem_rdata;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: randomized and directed bursts against a byte-array
// model of the RAM; read data expectations go through exp_q.
module tb_axi_ram_slave;
  import axi_ram_pkg::*;

  logic clk;
  logic rst_n;
  w_state_t w_dbg;
  r_state_t r_dbg;

  axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

  axi_ram_slave #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi_s      (bus),
    .w_state_dbg(w_dbg),
    .r_state_dbg(r_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  model [0:65535];
  logic [31:0] wdata_q [$];
  logic [3:0]  wstrb_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte address of beat i, computed directly from the burst rules.
  function automatic int beat_addr(input int start, input int size, input int len,
                                   input int burst, input int i);
    int bytes;
`ifdef AXI_RAM_WRAP_BURST_EN
    int wsz;
    int base;
`endif
    bytes = 1 << ((size > 2) ? 2 : size);
    if (burst == 0) return start;
`ifdef AXI_RAM_WRAP_BURST_EN
    if (burst == 2) begin
      wsz  = bytes * (len + 1);
      base = start - (start % wsz);
      return base + ((start - (start % bytes) - base + i * bytes) % wsz);
    end
`endif
    if (i == 0) return start;
    return ((start / bytes) * bytes + i * bytes) % 65536;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    int w;
    w = a - (a % 4);
    return {model[w+3], model[w+2], model[w+1], model[w]};
  endfunction

  // ---------------- driver tasks (enter and leave just after negedge) ----
  task automatic send_aw(input int id, input int addr, input int len, input int size, input int burst);
    int t;
    bus.awid = 4'(id); bus.awaddr = 16'(addr); bus.awlen = 8'(len);
    bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 100) begin @(negedge clk); t++; end
    if (!bus.awready) chk("aw_timeout", 32'(bus.awready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input int addr, input int len, input int size, input int burst, input int nbeats);
    int i, t, w;
    bit may_gap;
    i = 0; t = 0; may_gap = 1'b1;
    while (i < nbeats && t < 3000) begin
      if (may_gap && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
      end else begin
        bus.wvalid = 1'b1;
        bus.wdata  = wdata_q[i];
        bus.wstrb  = wstrb_q[i];
        bus.wlast  = (i == len);
      end
      may_gap = 1'b0;
      if (bus.wvalid && bus.wready) begin
        w = beat_addr(addr, size, len, burst, i);
        w = w - (w % 4);
        for (int l = 0; l < 4; l++)
          if (wstrb_q[i][l]) model[w+l] = wdata_q[i][l*8 +: 8];
        i++;
        may_gap = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    if (i < nbeats) chk("w_timeout", 32'(i), 32'(nbeats));
  endtask

  task automatic recv_b(input int id);
    int t, d;
    t = 0;
    while (!bus.bvalid && t < 100) begin @(negedge clk); t++; end
    chk("bvalid", 32'(bus.bvalid), 32'd1);
    chk("bid", 32'(bus.bid), 32'(id & 15));
    chk("bresp", 32'(bus.bresp), 32'd0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(negedge clk);
      chk("b_hold", 32'(bus.bvalid), 32'd1);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("b_drop", 32'(bus.bvalid), 32'd0);
    chk("awready_back", 32'(bus.awready), 32'd1);
  endtask

  task automatic axi_write(input int id, input int addr, input int len, input int size, input int burst);
    send_aw(id, addr, len, size, burst);
    send_w(addr, len, size, burst, len + 1);
    recv_b(id);
  endtask

  task automatic axi_read(input int id, input int addr, input int len, input int size, input int burst);
    int t, d;
    logic [31:0] e;
    bus.arid = 4'(id); bus.araddr = 16'(addr); bus.arlen = 8'(len);
    bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 100) begin @(negedge clk); t++; end
    if (!bus.arready) chk("ar_timeout", 32'(bus.arready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    got_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back(model_word(beat_addr(addr, size, len, burst, i)));
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!bus.rvalid && t < 100) begin @(negedge clk); t++; end
      d = $urandom_range(0, 2);
      repeat (d) begin
        chk("r_hold", 32'(bus.rvalid), 32'd1);
        @(negedge clk);
      end
      e = exp_q.pop_front();
      chk("rvalid", 32'(bus.rvalid), 32'd1);
      chk("rdata", bus.rdata, e);
      chk("rid", 32'(bus.rid), 32'(id & 15));
      chk("rlast", 32'(bus.rlast), 32'(i == len));
      chk("rresp", 32'(bus.rresp), 32'd0);
      got_q.push_back(bus.rdata);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk("rvalid_gap", 32'(bus.rvalid), 32'd0);
      chk("rlast_low", 32'(bus.rlast), 32'd0);
    end
    chk("arready_back", 32'(bus.arready), 32'd1);
  endtask

  task automatic fill(input int n, input bit rnd_strb);
    wdata_q.delete(); wstrb_q.delete();
    for (int i = 0; i < n; i++) begin
      wdata_q.push_back($urandom());
      wstrb_q.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, len, size, burst;
    for (int i = 0; i < 65536; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    chk("rst_rid", 32'(bus.rid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
    chk("rst_wdbg", 32'(w_dbg), 32'(W_IDLE));
    chk("rst_rdbg", 32'(r_dbg), 32'(R_IDLE));

    // known-zero contents for the regions used below (max LEN=255)
    wdata_q.delete(); wstrb_q.delete();
    for (int i = 0; i < 256; i++) begin wdata_q.push_back(32'd0); wstrb_q.push_back(4'hF); end
    axi_write(0, 'h0000, 255, 2, 1);
    axi_write(0, 'hFF00, 63, 2, 1);

    // unaligned INCR with partial strobes
    wdata_q = '{32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF};
    wstrb_q = '{4'hF, 4'hF, 4'b1001};
    axi_write(1, 1, 2, 2, 1);
    axi_read(1, 1, 2, 2, 1);
    chk("plan_beat2", got_q[2], 32'hFF0000FF);

    // FIXED: last beat wins
    wdata_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    wstrb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(2, 'h10, 3, 2, 0);
    axi_read(2, 'h10, 0, 2, 1);
    chk("fixed_last", got_q[0], 32'd4);

    // address wrap at top of memory
    wdata_q = '{32'hAAAA5555, 32'hBEEFCAFE};
    wstrb_q = '{4'hF, 4'hF};
    axi_write(3, 'hFFFC, 1, 2, 1);
    axi_read(3, 'h0000, 0, 2, 1);
    chk("wrap_top", got_q[0], 32'hBEEFCAFE);
    axi_read(3, 'hFFFC, 0, 2, 1);

    // reset mid-burst: first beat stays, FSMs idle at once
    fill(4, 1'b0);
    send_aw(5, 'h40, 3, 2, 1);
    send_w('h40, 3, 2, 1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_awready", 32'(bus.awready), 32'd1);
    chk("mid_wready", 32'(bus.wready), 32'd0);
    chk("mid_bvalid", 32'(bus.bvalid), 32'd0);
    chk("mid_wdbg", 32'(w_dbg), 32'(W_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(2, 1'b1);
    axi_write(6, 'h80, 1, 2, 1);
    axi_read(6, 'h40, 3, 2, 1);
    axi_read(7, 'h80, 1, 2, 1);

`ifdef AXI_RAM_WRAP_BURST_EN
    wdata_q = '{32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 32'h0000_0004};
    wstrb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(8, 'h08, 3, 2, 2);
    axi_read(8, 'h00, 3, 2, 1);
    chk("wrap_w0", got_q[0], 32'h0000_0000);
    chk("wrap_w2", got_q[2], 32'h0000_0008);
    axi_read(8, 'h04, 3, 2, 2);
`endif

    // randomized bursts
    for (int n = 0; n < 40; n++) begin
      a     = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 'h3C0) : $urandom_range('hFFC0, 'hFFFF);
      len   = $urandom_range(0, 7);
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
`ifdef AXI_RAM_WRAP_BURST_EN
      if (burst == 2) len = (1 << $urandom_range(1, 3)) - 1;
`endif
      fill(len + 1, 1'b1);
      axi_write($urandom_range(0, 15), a, len, size, burst);
      a     = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 'h3C0) : $urandom_range('hFFC0, 'hFFFF);
      len   = $urandom_range(0, 7);
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
`ifdef AXI_RAM_WRAP_BURST_EN
      if (burst == 2) len = (1 << $urandom_range(1, 3)) - 1;
`endif
      axi_read($urandom_range(0, 15), a, len, size, burst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
